// File: rtl/vec_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_seq_pkg
//  Description : Shared types and width helpers for the vector issue
//                sequencer: vector-length / element-index width functions,
//                the default-configuration FIFO entry layout and the FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_seq_pkg;

    localparam int VECTOR_ELEM_DEF = 4;
    localparam int INSTR_W_DEF     = 32;

    // Width able to hold a vector length 0..elem inclusive.
    function automatic int vl_width(input int elem);
        return $clog2(elem + 1);
    endfunction

    // Width of an element index 0..elem-1 (at least one bit).
    function automatic int idx_width(input int elem);
        return (elem > 1) ? $clog2(elem) : 1;
    endfunction

    localparam int VL_W  = vl_width(VECTOR_ELEM_DEF);
    localparam int IDX_W = idx_width(VECTOR_ELEM_DEF);

    // Buffered instruction for the default configuration.
    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [VL_W-1:0]        vl;
    } vec_seq_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/vector_issue_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vector_issue_sequencer_if
//  Description : Micro-op channel from the sequencer to the execution lanes.
//                master : sequencer (drives uop_valid/instr/base/mask/last)
//                slave  : lanes     (drives uop_ready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vector_issue_sequencer_if #(
    parameter int INSTR_W = 32,
    parameter int IDX_W   = 2,
    parameter int LANES   = 4
);
    logic               uop_valid;
    logic               uop_ready;
    logic [INSTR_W-1:0] uop_instr;
    logic [IDX_W-1:0]   uop_base;
    logic [LANES-1:0]   uop_mask;
    logic               uop_last;

    modport master (
        output uop_valid, uop_instr, uop_base, uop_mask, uop_last,
        input  uop_ready
    );

    modport slave (
        input  uop_valid, uop_instr, uop_base, uop_mask, uop_last,
        output uop_ready
    );
endinterface
`default_nettype wire

// File: rtl/vec_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vec_seq_fifo
//  Description : Synchronous FIFO with push/pop/flush. Pointers carry one
//                extra wrap bit so full and empty are told apart by the MSB.
//  Ports       : clk, rst (sync, active high), flush, push, wdata, pop,
//                rdata (head, combinational), full, empty, count
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     flush,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         wdata,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;
endmodule
`default_nettype wire

// File: rtl/vector_issue_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vector_issue_sequencer
//  Description : Buffers vector instructions and splits each into element-
//                group micro-ops of VECTOR_ACTIVE_EL elements, issuing at
//                most one per cycle under valid/ready.
//  Ports       : clk, rst (sync, active high), flush,
//                valid_in/instr_in/vl_in -> pop (front-end handoff),
//                uop (vector_issue_sequencer_if.master, lane channel),
//                busy; perf_uops/perf_stall with VEC_SEQ_PERF_EN.
//  Options     : `define VEC_SEQ_PERF_EN adds handshake / stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_issue_sequencer
    import vec_seq_pkg::*;
#(
    parameter int VECTOR_ELEM      = 4,
    parameter int VECTOR_ACTIVE_EL = 4,
    parameter int FIFO_DEPTH       = 4,
    parameter int INSTR_W          = 32
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              flush,
    input  wire logic                              valid_in,
    input  wire logic [INSTR_W-1:0]                instr_in,
    input  wire logic [vl_width(VECTOR_ELEM)-1:0]  vl_in,
    output logic                                   pop,
    output logic                                   busy,
    vector_issue_sequencer_if.master               uop
`ifdef VEC_SEQ_PERF_EN
    ,
    output logic [31:0]                            perf_uops,
    output logic [31:0]                            perf_stall
`endif
);
    localparam int VLW   = vl_width(VECTOR_ELEM);
    localparam int IDXW  = idx_width(VECTOR_ELEM);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int EW    = INSTR_W + VLW;
    localparam logic [VLW-1:0] c_vl_max = VLW'(VECTOR_ELEM);
    localparam logic [VLW:0]   c_step   = (VLW+1)'(VECTOR_ACTIVE_EL);

    seq_state_e                r_state, w_state_nxt;
    logic [IDXW-1:0]           r_elem, w_elem_nxt;
    logic [EW-1:0]             w_head;
    logic [INSTR_W-1:0]        w_head_instr;
    logic [VLW-1:0]            w_head_vl;
    logic [VLW-1:0]            w_vl_clamp;
    logic [VLW:0]              w_base_ext;
    logic [VECTOR_ACTIVE_EL-1:0] w_mask;
    logic                      w_full, w_empty, w_deq, w_valid, w_last;
    logic [CNT_W-1:0]          w_count;

    assign w_vl_clamp = (vl_in > c_vl_max) ? c_vl_max : vl_in;
    // A full FIFO refuses even if the head retires this cycle.
    assign pop = valid_in & ~w_full & ~flush & ~rst;

    vec_seq_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (pop),
        .wdata ({instr_in, w_vl_clamp}),
        .pop   (w_deq),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_head_instr = w_head[EW-1:VLW];
    assign w_head_vl    = w_head[VLW-1:0];

    // Lane masking and last detection in a width that cannot overflow.
    assign w_base_ext = (VLW+1)'(r_elem);
    assign w_last     = (w_base_ext + c_step) >= {1'b0, w_head_vl};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < VECTOR_ACTIVE_EL; i++) begin
            w_mask[i] = (w_base_ext + (VLW+1)'(i)) < {1'b0, w_head_vl};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_elem  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_elem  <= w_elem_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_elem_nxt  = r_elem;
        w_deq       = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                w_elem_nxt = '0;
                if (!w_empty) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                w_valid = (w_head_vl != '0);
                if (!w_valid) begin
                    // Zero-length instruction retires silently.
                    w_deq = 1'b1;
                end else if (uop.uop_ready) begin
                    if (w_last) w_deq = 1'b1;
                    else        w_elem_nxt = r_elem + IDXW'(VECTOR_ACTIVE_EL);
                end
                if (w_deq) begin
                    w_elem_nxt = '0;
                    // Only entries already behind the head avoid a bubble.
                    w_state_nxt = (w_count > CNT_W'(1)) ? ISSUE : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_valid     = 1'b0;
            w_deq       = 1'b0;
            w_state_nxt = IDLE;
            w_elem_nxt  = '0;
        end
    end

    assign uop.uop_valid = w_valid;
    assign uop.uop_instr = w_valid ? w_head_instr : '0;
    assign uop.uop_base  = w_valid ? r_elem : '0;
    assign uop.uop_mask  = w_valid ? w_mask : '0;
    assign uop.uop_last  = w_valid & w_last;

    assign busy = ~w_empty | (r_state != IDLE);

`ifdef VEC_SEQ_PERF_EN
    logic [31:0] r_perf_uops;
    logic [31:0] r_perf_stall;

    // Flush does not clear these; w_valid is already low during flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_uops  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_valid &  uop.uop_ready) r_perf_uops  <= r_perf_uops + 32'd1;
            if (w_valid & ~uop.uop_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_uops  = r_perf_uops;
    assign perf_stall = r_perf_stall;
`endif
endmodule
`default_nettype wire

// File: tb/tb_vector_issue_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vector_issue_sequencer
//  Description : Scoreboard bench for vector_issue_sequencer with
//                VECTOR_ELEM=4, VECTOR_ACTIVE_EL=2, FIFO_DEPTH=4.
//                Expected micro-ops are queued when an instruction is
//                accepted and compared at each lane handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_issue_sequencer;
    import vec_seq_pkg::*;

    localparam int VE   = 4;
    localparam int AEL  = 2;
    localparam int FD   = 4;
    localparam int IW   = 32;
    localparam int VLW  = vl_width(VE);
    localparam int IDXW = idx_width(VE);

    typedef struct packed {
        logic [IW-1:0]   instr;
        logic [IDXW-1:0] base;
        logic [AEL-1:0]  mask;
        logic            last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           valid_in;
    logic [IW-1:0]  instr_in;
    logic [VLW-1:0] vl_in;
    logic           pop;
    logic           busy;
`ifdef VEC_SEQ_PERF_EN
    logic [31:0]    perf_uops;
    logic [31:0]    perf_stall;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    int   n_hs  = 0;
    exp_t sb[$];

    vector_issue_sequencer_if #(.INSTR_W(IW), .IDX_W(IDXW), .LANES(AEL)) uif ();

    vector_issue_sequencer #(
        .VECTOR_ELEM      (VE),
        .VECTOR_ACTIVE_EL (AEL),
        .FIFO_DEPTH       (FD),
        .INSTR_W          (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .valid_in   (valid_in),
        .instr_in   (instr_in),
        .vl_in      (vl_in),
        .pop        (pop),
        .busy       (busy),
        .uop        (uif)
`ifdef VEC_SEQ_PERF_EN
        ,
        .perf_uops  (perf_uops),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void expect_instr(input logic [IW-1:0] ins, input int vl);
        int v;
        v = (vl > VE) ? VE : vl;
        for (int b = 0; b < v; b += AEL) begin
            exp_t e;
            e.instr = ins;
            e.base  = b[IDXW-1:0];
            for (int i = 0; i < AEL; i++) e.mask[i] = (b + i < v);
            e.last  = (b + AEL >= v);
            sb.push_back(e);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IW-1:0] ins, input int vl, output int waits);
        waits    = 0;
        valid_in = 1'b1;
        instr_in = ins;
        vl_in    = vl[VLW-1:0];
        #1;
        while (!pop && waits < 64) begin
            tick();
            waits++;
        end
        if (!pop) chk("send_timeout", 64'(pop), 64'd1);
        else      expect_instr(ins, vl);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_sb"}, 64'(sb.size()), 64'd0);
    endtask

    // Lane-side monitor: scoreboard compare plus hold-while-stalled check.
    logic prev_stall = 1'b0;
    exp_t prev_obs;
    always @(negedge clk) begin
        exp_t obs;
        exp_t e;
        obs = {uif.uop_instr, uif.uop_base, uif.uop_mask, uif.uop_last};
        if (rst || flush) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(uif.uop_valid), 64'd1);
                chk("hold_fields", 64'(obs), 64'(prev_obs));
            end
            if (uif.uop_valid && uif.uop_ready) begin
                n_hs++;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_uop", 64'(obs), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("uop_instr", 64'(uif.uop_instr), 64'(e.instr));
                    chk("uop_base",  64'(uif.uop_base),  64'(e.base));
                    chk("uop_mask",  64'(uif.uop_mask),  64'(e.mask));
                    chk("uop_last",  64'(uif.uop_last),  64'(e.last));
                end
            end
            prev_stall = uif.uop_valid && !uif.uop_ready;
            prev_obs   = obs;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; flush = 1'b0; valid_in = 1'b0;
        instr_in = '0; vl_in = '0; uif.uop_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_pop",   64'(pop),           64'd0);
        chk("rst_valid", 64'(uif.uop_valid), 64'd0);
        chk("rst_base",  64'(uif.uop_base),  64'd0);
        chk("rst_mask",  64'(uif.uop_mask),  64'd0);
        chk("rst_last",  64'(uif.uop_last),  64'd0);
        chk("rst_busy",  64'(busy),          64'd0);
`ifdef VEC_SEQ_PERF_EN
        chk("rst_perf_uops",  64'(perf_uops),  64'd0);
        chk("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif

        // vl=3 split into two micro-ops, latency and busy fall
        uif.uop_ready = 1'b1;
        send(32'hA0, 3, w);
        chk("lat_n1_valid", 64'(uif.uop_valid), 64'd0);
        tick();
        chk("lat_n2_valid", 64'(uif.uop_valid), 64'd1);
        tick();
        chk("a_busy_mid", 64'(busy), 64'd1);
        tick();
        chk("a_busy_done", 64'(busy), 64'd0);
        chk("a_sb_empty", 64'(sb.size()), 64'd0);

        // Fill the FIFO while stalled; fifth request waits for a dequeue
        uif.uop_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(32'hB0 + 32'(k), 4, w);
            chk("fill_pop_wait", 64'(w), 64'd0);
        end
        valid_in = 1'b1; instr_in = 32'hB4; vl_in = VLW'(4);
        #1;
        chk("full_pop_a", 64'(pop), 64'd0);
        tick();
        chk("full_pop_b", 64'(pop), 64'd0);
        tick();
        chk("full_pop_c", 64'(pop), 64'd0);
        uif.uop_ready = 1'b1;
        #1;
        chk("full_pop_hs0", 64'(pop), 64'd0);
        tick();
        chk("full_pop_deq", 64'(pop), 64'd0);
        tick();
        chk("full_pop_free", 64'(pop), 64'd1);
        if (pop) expect_instr(32'hB4, 4);
        tick();
        valid_in = 1'b0;
        drain("b");

        // vl=0 then vl=2
        send(32'hC0, 0, w);
        send(32'hC1, 2, w);
        chk("vl0_no_uop", 64'(uif.uop_valid), 64'd0);
        tick();
        chk("vl2_valid", 64'(uif.uop_valid), 64'd1);
        chk("vl2_base",  64'(uif.uop_base),  64'd0);
        chk("vl2_mask",  64'(uif.uop_mask),  64'd3);
        chk("vl2_last",  64'(uif.uop_last),  64'd1);
        drain("c");

        // Ready toggling mid-instruction; oversized vl clamps to VE
        uif.uop_ready = 1'b0;
        send(32'hD0, 4, w);
        send(32'hD1, 7, w);
        send(32'hD2, 1, w);
        for (int i = 0; i < 24; i++) begin
            uif.uop_ready = 1'($urandom_range(0, 1));
            tick();
        end
        uif.uop_ready = 1'b1;
        drain("d");

        // Flush with three entries queued mid-issue
        uif.uop_ready = 1'b0;
        send(32'hE0, 4, w);
        send(32'hE1, 4, w);
        send(32'hE2, 4, w);
        uif.uop_ready = 1'b1;
        tick();
        flush = 1'b1; valid_in = 1'b1; instr_in = 32'hEE; vl_in = VLW'(2);
        #1;
        chk("flush_pop",   64'(pop),           64'd0);
        chk("flush_valid", 64'(uif.uop_valid), 64'd0);
        tick();
        flush = 1'b0; valid_in = 1'b0;
        sb.delete();
        chk("post_flush_valid", 64'(uif.uop_valid), 64'd0);
        chk("post_flush_busy",  64'(busy),          64'd0);
        send(32'hE9, 2, w);
        tick();
        chk("post_flush_uop_valid", 64'(uif.uop_valid), 64'd1);
        chk("post_flush_uop_base",  64'(uif.uop_base),  64'd0);
        drain("e");
`ifdef VEC_SEQ_PERF_EN
        chk("perf_uops_run", 64'(perf_uops), 64'(n_hs));
`endif

        // Reset mid-issue
        uif.uop_ready = 1'b0;
        send(32'hF0, 4, w);
        send(32'hF1, 4, w);
        uif.uop_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        n_hs = 0;
        chk("mid_rst_valid", 64'(uif.uop_valid), 64'd0);
        chk("mid_rst_base",  64'(uif.uop_base),  64'd0);
        chk("mid_rst_mask",  64'(uif.uop_mask),  64'd0);
        chk("mid_rst_last",  64'(uif.uop_last),  64'd0);
        chk("mid_rst_busy",  64'(busy),          64'd0);
        chk("mid_rst_pop",   64'(pop),           64'd0);
`ifdef VEC_SEQ_PERF_EN
        chk("mid_rst_perf_uops",  64'(perf_uops),  64'd0);
        chk("mid_rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
        send(32'hF2, 4, w);
        drain("f");
`ifdef VEC_SEQ_PERF_EN
        chk("perf_uops_after_rst", 64'(perf_uops), 64'd2);
`endif
        chk("hs_after_rst", 64'(n_hs), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vector_issue_sequencer.md
Name: vector_issue_sequencer

Overview:
- Sits between the vector front-end instruction handoff and the vector execution lanes.
- Buffers incoming vector instructions in a small FIFO.
- Splits each instruction into element-group micro-ops of VECTOR_ACTIVE_EL elements each, covering the instruction's vector length.
- Issues micro-ops to the lanes under a valid/ready handshake, one per cycle at most.

Parameters:
- VECTOR_ELEM, 4, max elements per vector register (VLMAX); power of 2, ≥ VECTOR_ACTIVE_EL.
- VECTOR_ACTIVE_EL, 4, elements processed per micro-op (lane count); power of 2.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, ≥ 2.
- INSTR_W, 32, width of opaque instruction payload.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, synchronous active-high reset.
- flush, in, 1, discard all buffered and in-flight instructions.
- valid_in, in, 1, front-end presents an instruction.
- instr_in, in, INSTR_W, opaque instruction payload.
- vl_in, in, VL_W = $clog2(VECTOR_ELEM+1), requested vector length.
- pop, out, 1, instruction accepted this cycle (front-end advances).
- uop_valid, out, 1, micro-op presented to lanes.
- uop_ready, in, 1, lanes accept micro-op.
- uop_instr, out, INSTR_W, payload of current instruction.
- uop_base, out, $clog2(VECTOR_ELEM), first element index of micro-op.
- uop_mask, out, VECTOR_ACTIVE_EL, per-lane active mask.
- uop_last, out, 1, final micro-op of the instruction.
- busy, out, 1, FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (rst=1 at an edge): FIFO empty, pointers 0, FSM=IDLE, element counter 0. Outputs pop=0, uop_valid=0, uop_base=0, uop_mask=0, uop_last=0, busy=0. rst overrides flush and everything else.
- Accept: pop = valid_in & ~full & ~flush, combinational. On pop, {instr_in, min(vl_in, VECTOR_ELEM)} is written at the tail. A full FIFO does not accept, even if a dequeue happens in the same cycle.
- FSM states:
  - IDLE: go to ISSUE when FIFO non-empty; elem counter := 0.
  - ISSUE: head entry drives the uop fields.
    - uop_valid = 1 when head vl > 0.
    - uop_base = elem counter.
    - uop_mask[i] = (uop_base + i < vl).
    - uop_last = (uop_base + VECTOR_ACTIVE_EL ≥ vl).
    - On uop_valid & uop_ready & ~uop_last: elem counter += VECTOR_ACTIVE_EL.
    - On uop_valid & uop_ready & uop_last: dequeue head, counter := 0. Stay in ISSUE if another entry remains (back-to-back, no bubble), else IDLE.
  - vl=0 entry: one ISSUE cycle with uop_valid=0, then dequeue (no micro-op).
- While uop_valid=1 and uop_ready=0, all uop_* outputs are held stable.
- Latency: instruction accepted in cycle N → first micro-op valid at N+1 (FIFO empty, FSM IDLE) → at N+2. Define exactly as: IDLE→ISSUE takes one cycle; uop_valid first asserts at N+2.
- Throughput: one micro-op per cycle while uop_ready=1. Total micro-ops per instruction = ceil(vl/VECTOR_ACTIVE_EL).
- Pointer wrap: pointers are log2(FIFO_DEPTH)+1 bits. Full/empty are derived from the MSB compare.
- Simultaneous push and dequeue on a non-full FIFO: both happen; occupancy is unchanged.
- flush: at the next edge, FIFO empty, FSM=IDLE, counter 0. While flush is high, pop=0 and uop_valid=0. A micro-op handshake in the flush cycle is ignored.

Optional Feature:
- Macro VEC_SEQ_PERF_EN.
- When defined: adds outputs perf_uops (32b, count of micro-op handshakes) and perf_stall (32b, cycles with uop_valid & ~uop_ready). Both reset to 0 on rst, are unaffected by flush, and wrap at 2^32.
- When undefined: ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Package vec_seq_pkg holds:
  - localparam helpers VL_W and IDX_W;
  - typedef vec_seq_entry_t {instr, vl};
  - typedef enum seq_state_e {IDLE, ISSUE}.
- Sub-module vec_seq_fifo: parameterised synchronous FIFO with push/pop/flush and full/empty outputs. The sequencer instantiates it once.

Test Plan:
- VECTOR_ELEM=4, ACTIVE_EL=2, vl=3, uop_ready=1:
  - 2 micro-ops: base 0 mask 11 last 0, then base 2 mask 01 last 1;
  - busy falls after the last handshake.
- 4 instrs with vl=4 while uop_ready=0:
  - pop high for 4 cycles;
  - 5th valid_in gets pop=0 until the first dequeue completes.
- vl=0 followed by vl=2:
  - no micro-op for the first instruction;
  - a single micro-op (base 0, mask 11, last 1) for the second, one cycle later.
- uop_ready toggled 0/1 mid-instruction: uop_base/mask/instr stable while stalled; no micro-op duplicated or skipped.
- flush asserted with 3 entries queued mid-issue: next cycle uop_valid=0, busy=0, pop=0 during flush; a new instruction afterwards issues from base 0.
- rst asserted mid-ISSUE: all outputs 0 next cycle; with VEC_SEQ_PERF_EN, perf_uops=0 after reset and increments 1 per handshake.
